serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder for the arithmetic datapath. It is the stage directly downstream of the one-bit full adder cell and consumes that cell's sum/carryout every clock. Operands load in parallel, and one bit pair per cycle, LSB first, passes through a single full adder cell. A registered carry closes the loop between bits. The block trades area for latency; the ALU control uses it where WIDTH parallel cells are not affordable.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  request to begin an addition; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- carryin  input  1  initial carry; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- sum  output  WIDTH  result register.
- carryout  output  1  carry out of the MSB.
- overflow  output  1  two's-complement overflow: the carry into the MSB XOR carryout.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, with start=1: load the a and b shift registers. Set carry_q = carryin. Clear the bit counter. Clear the sum shift register. Go to RUN.
- IDLE, with start=0: hold all state.
- RUN, each cycle:
  - The cell adds a_sr[0], b_sr[0] and carry_q.
  - The cell's sum shifts into sum_sr at the MSB end, and sum_sr shifts right.
  - a_sr and b_sr shift right.
  - carry_q takes the cell's carryout.
  - The counter increments.
  - When the counter equals WIDTH-2, capture c_msb_in = the cell's carryout. This is the carry into the MSB.
- RUN exits to DONE on the edge that processes bit WIDTH-1, i.e. counter == WIDTH-1. On that edge:
  - sum takes the final sum_sr value.
  - carryout takes the cell's carryout.
  - overflow = c_msb_in XOR the cell's carryout.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and in DONE. Operand inputs may change freely after the accepting edge.
- sum, carryout and overflow hold their values until the next completion or reset. They do not change during a later RUN.
- Counter width is $clog2(WIDTH). It never wraps inside a run.
- Reset has priority over everything:
  - state = IDLE;
  - busy=0, done=0, sum=0, carryout=0, overflow=0;
  - shift registers, carry_q and the counter are cleared.
- Reset mid-RUN abandons the operation. No done pulse is produced.

## Timing
- Let edge E0 be the rising edge at which start is accepted.
- busy is high from after E0 through WIDTH cycles. It falls after edge E0+WIDTH.
- done is high for the cycle between edges E0+WIDTH and E0+WIDTH+1.
- Latency from start to done is WIDTH+1 cycles.
- Throughput is one addition per WIDTH+2 cycles. The earliest next acceptance is edge E0+WIDTH+2.
- The cell is combinational (2 gate levels, 50 units per gate). The bench clock period is 500 time units, and inputs are driven 100 units after the rising edge.

## Structure
- Package serial_adder_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH.
- One sub-module: serial_adder_cell, a one-bit full adder.
  - Ports: sum, carryout, a, b, carryin.
  - Behaviour is identical to the team's existing full adder cell.
  - It is instantiated once.
- The FSM, counter and shift registers live in the top level.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, carryin=0, start for 1 cycle -> done exactly 9 cycles later; sum=0x8D, carryout=0, overflow=1.
- a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=1, overflow=0. Then a=0x7F, b=0x00, carryin=1 -> sum=0x80, carryout=0, overflow=1.
- start held high continuously, with a and b changing every cycle:
  - only the operands present at the IDLE edge are used;
  - done pulses every 10 cycles;
  - busy is low during DONE.
- reset asserted on the 4th RUN edge of a=0xAA+b=0x55 -> next cycle busy=0, done=0, sum=0, carryout=0. No done pulse follows. A new start afterwards gives the correct result.
- Exhaustive WIDTH=4 sweep of a, b and carryin against a reference {carryout,sum}=a+b+carryin -> every result matches; overflow matches the sign rule.
- WIDTH=2 corner: a=2'b11, b=2'b11, carryin=1 -> sum=2'b11, carryout=1, overflow=0, done 3 cycles after start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width. Imported by serial_adder.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      DONE = S_DONE
   } state_t;

endpackage

// File: rtl/serial_adder_cell.sv
// serial_adder_cell
// One-bit combinational full adder (two gate levels).
// Ports:
//   a, b      - operand bits
//   carryin   - carry into this bit
//   sum       - a ^ b ^ carryin
//   carryout  - carry out of this bit
module serial_adder_cell (
   output logic sum,
   output logic carryout,
   input  logic a,
   input  logic b,
   input  logic carryin
);

   always_comb begin
      sum      = a ^ b ^ carryin;
      carryout = (a & b) | (carryin & (a ^ b));
   end

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial WIDTH-bit adder. Operands load in parallel when start is seen
// in IDLE; one bit pair per cycle (LSB first) goes through a single full
// adder cell with a registered carry closing the loop. After WIDTH cycles
// the result, carry out and two's-complement overflow are registered and
// done pulses for one cycle.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start              - begin an addition (accepted only in IDLE)
//   a, b, carryin      - operands and initial carry, sampled on acceptance
//   busy               - high while bits are being processed
//   done               - one-cycle pulse when the result becomes valid
//   sum, carryout      - result registers, held until the next completion
//   overflow           - carry into MSB XOR carry out of MSB
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             c_msb_in;
   logic             cell_sum, cell_co;
   logic             load, step, finish;

   serial_adder_cell u_cell (
      .sum      (cell_sum),
      .carryout (cell_co),
      .a        (a_sr[0]),
      .b        (b_sr[0]),
      .carryin  (carry_q)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         cnt      <= '0;
         carry_q  <= 1'b0;
         c_msb_in <= 1'b0;
         sum      <= '0;
         carryout <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         a_sr    <= a;
         b_sr    <= b;
         sum_sr  <= '0;
         cnt     <= '0;
         carry_q <= carryin;
      end else if (step) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         sum_sr  <= {cell_sum, sum_sr[WIDTH-1:1]};
         carry_q <= cell_co;
         // Hold on the last bit so the counter never wraps when WIDTH is a
         // power of two; the next load clears it anyway.
         if (!finish) cnt <= cnt + CW'(1);
         // Carry produced by bit WIDTH-2 is the carry into the MSB.
         if (cnt == CNT_MSB_IN) c_msb_in <= cell_co;
         if (finish) begin
            sum      <= {cell_sum, sum_sr[WIDTH-1:1]};
            carryout <= cell_co;
            overflow <= c_msb_in ^ cell_co;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Scoreboard bench for serial_adder at WIDTH 8, 4 and 2. Stimulus pushes
// the expected result and completion cycle into a per-instance queue; a
// monitor per instance pops and compares whenever done is seen.
module tb_serial_adder;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   exp_t q8[$];
   exp_t q4[$];
   exp_t q2[$];
   logic [31:0] last8 = '0, last4 = '0, last2 = '0;

   logic       start8 = 1'b0, ci8 = 1'b0, busy8, done8, co8, ov8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       start4 = 1'b0, ci4 = 1'b0, busy4, done4, co4, ov4;
   logic [3:0] a4 = '0, b4 = '0, sum4;
   logic       start2 = 1'b0, ci2 = 1'b0, busy2, done2, co2, ov2;
   logic [1:0] a2 = '0, b2 = '0, sum2;

   always #250 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .carryin(ci8),
      .busy(busy8), .done(done8), .sum(sum8), .carryout(co8), .overflow(ov8));
   serial_adder #(.WIDTH(4)) u4 (
      .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .carryin(ci4),
      .busy(busy4), .done(done4), .sum(sum4), .carryout(co4), .overflow(ov4));
   serial_adder #(.WIDTH(2)) u2 (
      .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .carryin(ci2),
      .busy(busy2), .done(done2), .sum(sum2), .carryout(co2), .overflow(ov2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference: {carryout,sum} = a + b + carryin; overflow by the sign rule.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input int c);
      exp_t        e;
      logic [32:0] full;
      logic [31:0] mask;
      mask  = (32'd1 << w) - 32'd1;
      full  = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, ci};
      e.s   = full[31:0] & mask;
      e.co  = full[w];
      e.ov  = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
      e.cyc = c;
      return e;
   endfunction

   // Monitors
   always @(negedge clk) begin
      if (done8) begin
         if (q8.size() == 0) chk("w8 done with no pending op", 0, 1);
         else begin
            exp_t e;
            e = q8.pop_front();
            chk("w8 sum", sum8, e.s);
            chk("w8 carryout", co8, e.co);
            chk("w8 overflow", ov8, e.ov);
            chk("w8 done cycle", cyc, e.cyc);
            chk("w8 busy in DONE", busy8, 0);
            last8 = e.s;
         end
      end else if (busy8) chk("w8 sum held during run", sum8, last8);
   end

   always @(negedge clk) begin
      if (done4) begin
         if (q4.size() == 0) chk("w4 done with no pending op", 0, 1);
         else begin
            exp_t e;
            e = q4.pop_front();
            chk("w4 sum", sum4, e.s);
            chk("w4 carryout", co4, e.co);
            chk("w4 overflow", ov4, e.ov);
            chk("w4 done cycle", cyc, e.cyc);
            last4 = e.s;
         end
      end else if (busy4) chk("w4 sum held during run", sum4, last4);
   end

   always @(negedge clk) begin
      if (done2) begin
         if (q2.size() == 0) chk("w2 done with no pending op", 0, 1);
         else begin
            exp_t e;
            e = q2.pop_front();
            chk("w2 sum", sum2, e.s);
            chk("w2 carryout", co2, e.co);
            chk("w2 overflow", ov2, e.ov);
            chk("w2 done cycle", cyc, e.cyc);
            last2 = e.s;
         end
      end else if (busy2) chk("w2 sum held during run", sum2, last2);
   end

   function automatic int qsize(input int w);
      case (w)
         8:       return q8.size();
         4:       return q4.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic drain(input int w);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (qsize(w) == 0) break;
      end
      chk($sformatf("w%0d result arrived in time", w), qsize(w), 0);
      case (w)
         8:       q8.delete();
         4:       q4.delete();
         default: q2.delete();
      endcase
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic eco, input logic eov);
      exp_t e;
      @(posedge clk); #100;
      a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
      e.s = {24'd0, es}; e.co = eco; e.ov = eov; e.cyc = cyc + 1 + 8;
      q8.push_back(e);
      @(posedge clk); #100;
      start8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~ci;
      drain(8);
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      @(posedge clk); #100;
      a4 = a; b4 = b; ci4 = ci; start4 = 1'b1;
      q4.push_back(model(4, {28'd0, a}, {28'd0, b}, ci, cyc + 1 + 4));
      @(posedge clk); #100;
      start4 = 1'b0; a4 = ~a; b4 = ~b;
      drain(4);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", busy8, 0);
      chk("reset done", done8, 0);
      chk("reset sum", sum8, 0);
      chk("reset carryout", co8, 0);
      chk("reset overflow", ov8, 0);
      chk("reset w4 sum", sum4, 0);
      @(posedge clk); #100;
      reset = 1'b0;

      // Directed vectors with hand-computed results.
      op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

      // start held high, operands changing every cycle.
      for (int k = 0; k < 30; k++) begin
         logic [7:0] va, vb;
         @(posedge clk); #100;
         va = 8'(k * 37 + 5);
         vb = 8'(k * 91 + 17);
         a8 = va; b8 = vb; ci8 = 1'b0; start8 = 1'b1;
         if (k % 10 == 0) q8.push_back(model(8, {24'd0, va}, {24'd0, vb}, 1'b0, cyc + 1 + 8));
      end
      @(posedge clk); #100;
      start8 = 1'b0;
      drain(8);

      // Reset on the 4th RUN edge of 0xAA + 0x55.
      @(posedge clk); #100;
      a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #100;
      start8 = 1'b0;
      @(posedge clk); #100;
      @(posedge clk); #100;
      @(negedge clk);
      chk("busy before abort", busy8, 1);
      @(posedge clk); #100;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort busy", busy8, 0);
      chk("abort done", done8, 0);
      chk("abort sum", sum8, 0);
      chk("abort carryout", co8, 0);
      chk("abort overflow", ov8, 0);
      last8 = '0; last4 = '0; last2 = '0;
      @(posedge clk); #100;
      reset = 1'b0;
      repeat (15) @(posedge clk);
      op8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);

      // WIDTH=2 corner: 3 + 3 + 1.
      @(posedge clk); #100;
      a2 = 2'b11; b2 = 2'b11; ci2 = 1'b1; start2 = 1'b1;
      begin
         exp_t e;
         e.s = 32'd3; e.co = 1'b1; e.ov = 1'b0; e.cyc = cyc + 1 + 2;
         q2.push_back(e);
      end
      @(posedge clk); #100;
      start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; ci2 = 1'b0;
      drain(2);

      // Exhaustive WIDTH=4 sweep.
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               op4(4'(ia), 4'(ib), 1'(ic));

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
